// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams operand bits LSB-first through an external
// 1-bit full-adder cell and assembles the WIDTH-bit sum plus final carry.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    // Counter keeps at least one bit so WIDTH=1 still has a legal register.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_RUN;
            S_RUN:  if (last_bit) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            S_RUN: begin
                // Sum bits arrive LSB-first, so they enter at the top and drift down.
                res_d   = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        fa_a      = (state_q == S_RUN) & a_q[0];
        fa_b      = (state_q == S_RUN) & b_q[0];
        fa_ci     = (state_q == S_RUN) & carry_q;
        out_sum   = res_q;
        out_cout  = carry_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH 8, 1 and 32, each driving a bench-side full-adder cell.
module tb_serial_add_ctrl;

    localparam int N_SWEEP = 12;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        vld  [3];
    logic        cin  [3];
    logic        ordy [3];
    logic [31:0] ina  [3];
    logic [31:0] inb  [3];
    wire         rdy  [3];
    wire         ovld [3];
    wire         fa_a [3];
    wire         fa_b [3];
    wire         fa_ci[3];
    wire         cout [3];
    wire  [31:0] osum [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic int wid(input int i);
        return (i == 0) ? 8 : (i == 1) ? 1 : 32;
    endfunction

    function automatic longint unsigned msk(input int i);
        return (64'd1 << wid(i)) - 64'd1;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : (g == 1) ? 1 : 32;
        logic [W-1:0] s;
        wire          fs;
        wire          fc;
        // External full-adder cell
        assign fs = fa_a[g] ^ fa_b[g] ^ fa_ci[g];
        assign fc = (fa_a[g] & fa_b[g]) | (fa_ci[g] & (fa_a[g] ^ fa_b[g]));
        serial_add_ctrl #(.WIDTH(W)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(vld[g]), .in_ready(rdy[g]),
            .in_a(ina[g][W-1:0]), .in_b(inb[g][W-1:0]), .in_cin(cin[g]),
            .fa_a(fa_a[g]), .fa_b(fa_b[g]), .fa_ci(fa_ci[g]),
            .fa_sum(fs), .fa_co(fc),
            .out_valid(ovld[g]), .out_ready(ordy[g]),
            .out_sum(s), .out_cout(cout[g])
        );
        assign osum[g] = 32'(s);
    end

    // Model: an accepted job is "edges since accept"; bits stream for W edges, then result is held.
    bit              m_act [3];
    int              m_cyc [3];
    longint unsigned m_a   [3];
    longint unsigned m_b   [3];
    bit              m_c   [3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_act[i] <= 1'b0;
                m_cyc[i] <= 0;
            end else if (!m_act[i]) begin
                if (vld[i]) begin
                    m_act[i] <= 1'b1;
                    m_cyc[i] <= 0;
                    m_a[i]   <= 64'(ina[i]) & msk(i);
                    m_b[i]   <= 64'(inb[i]) & msk(i);
                    m_c[i]   <= cin[i];
                end
            end else if (m_cyc[i] < wid(i)) begin
                m_cyc[i] <= m_cyc[i] + 1;
            end else if (ordy[i]) begin
                m_act[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                automatic int              w    = wid(i);
                automatic bit              run  = m_act[i] && (m_cyc[i] < w);
                automatic bit              done = m_act[i] && (m_cyc[i] == w);
                automatic longint unsigned tot  = m_a[i] + m_b[i] + 64'(m_c[i]);
                automatic longint unsigned lo   = (64'd1 << m_cyc[i]) - 64'd1;
                automatic longint unsigned ci   = 0;
                automatic longint unsigned ea   = 0;
                automatic longint unsigned eb   = 0;
                if (run) begin
                    ci = (((m_a[i] & lo) + (m_b[i] & lo) + 64'(m_c[i])) >> m_cyc[i]) & 64'd1;
                    ea = (m_a[i] >> m_cyc[i]) & 64'd1;
                    eb = (m_b[i] >> m_cyc[i]) & 64'd1;
                end
                chk($sformatf("w%0d_in_ready", w), 64'(rdy[i]), 64'(!m_act[i]));
                chk($sformatf("w%0d_out_valid", w), 64'(ovld[i]), 64'(done));
                chk($sformatf("w%0d_fa_a", w), 64'(fa_a[i]), ea);
                chk($sformatf("w%0d_fa_b", w), 64'(fa_b[i]), eb);
                chk($sformatf("w%0d_fa_ci", w), 64'(fa_ci[i]), ci);
                if (done) begin
                    chk($sformatf("w%0d_out_sum", w), 64'(osum[i]), tot & msk(i));
                    chk($sformatf("w%0d_out_cout", w), 64'(cout[i]), (tot >> w) & 64'd1);
                end
            end
        end
    end

    // Directed job on the WIDTH=8 instance with literal expectations.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold,
                       input logic [7:0] es, input logic ec, input int enci);
        int lat  = 0;
        int nci  = 0;
        int nrdy = 0;
        ordy[0] = (hold == 0);
        ina[0]  = {24'd0, a};
        inb[0]  = {24'd0, b};
        cin[0]  = c;
        vld[0]  = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        while (!ovld[0] && lat < 100) begin
            nci  += int'(fa_ci[0]);
            nrdy += int'(rdy[0]);
            @(posedge clk); #1;
            lat++;
        end
        chk("d_latency", 64'(lat), 64'd8);
        chk("d_sum", 64'(osum[0]), 64'(es));
        chk("d_cout", 64'(cout[0]), 64'(ec));
        chk("d_fa_ci_count", 64'(nci), 64'(enci));
        chk("d_ready_busy", 64'(nrdy), 64'd0);
        for (int h = 0; h < hold; h++) begin
            chk("d_hold_sum", 64'(osum[0]), 64'(es));
            chk("d_hold_cout", 64'(cout[0]), 64'(ec));
            chk("d_hold_valid", 64'(ovld[0]), 64'd1);
            chk("d_hold_ready", 64'(rdy[0]), 64'd0);
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("d_back_idle", 64'(rdy[0]), 64'd1);
        chk("d_valid_off", 64'(ovld[0]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int  acc  [3];
        int  last [3];
        bit  rb   [3];
        int  nv;
        bit  all_done;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; cin[i] = 1'b0; ordy[i] = 1'b1; ina[i] = '0; inb[i] = '0;
        end
        #1 rst_n = 1'b0;
        #11;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 64'(rdy[i]), 64'd1);
            chk("rst_out_valid", 64'(ovld[i]), 64'd0);
            chk("rst_out_sum", 64'(osum[i]), 64'd0);
            chk("rst_out_cout", 64'(cout[i]), 64'd0);
            chk("rst_fa", 64'({fa_a[i], fa_b[i], fa_ci[i]}), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 7);
        op8(8'hA5, 8'h5A, 1'b1, 0, 8'h00, 1'b1, 8);
        op8(8'h3C, 8'h0F, 1'b0, 5, 8'h4B, 1'b0, 4);

        // Abort mid-RUN with reset.
        ina[0] = 32'hFF; inb[0] = 32'hFF; cin[0] = 1'b0; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("r_pre_fa_a", 64'(fa_a[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("r_out_sum", 64'(osum[0]), 64'd0);
        chk("r_out_cout", 64'(cout[0]), 64'd0);
        chk("r_out_valid", 64'(ovld[0]), 64'd0);
        chk("r_fa", 64'({fa_a[0], fa_b[0], fa_ci[0]}), 64'd0);
        chk("r_in_ready", 64'(rdy[0]), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        nv = 0;
        repeat (15) begin
            @(posedge clk); #1;
            nv += int'(ovld[0]);
        end
        chk("r_no_result", 64'(nv), 64'd0);
        chk("r_ready_after", 64'(rdy[0]), 64'd1);

        // Back-to-back sweep on all widths; first job per width is the all-ones corner.
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0; last[i] = -1; ordy[i] = 1'b1;
            ina[i] = 32'(msk(i)); inb[i] = 32'(msk(i)); cin[i] = 1'b1; vld[i] = 1'b1;
        end
        for (int cyc = 1; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) rb[i] = rdy[i];
            @(posedge clk); #1;
            all_done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && rb[i]) begin
                    if (last[i] >= 0)
                        chk($sformatf("w%0d_interval", wid(i)), 64'(cyc - last[i]), 64'(wid(i) + 2));
                    last[i] = cyc;
                    acc[i]++;
                    if (acc[i] == N_SWEEP) begin
                        vld[i] = 1'b0;
                    end else begin
                        ina[i] = $urandom() & 32'(msk(i));
                        inb[i] = $urandom() & 32'(msk(i));
                        cin[i] = 1'($urandom_range(0, 1));
                    end
                end
                if (acc[i] < N_SWEEP) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("w%0d_sweep_count", wid(i)), 64'(acc[i]), 64'(N_SWEEP));
        repeat (40) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001: The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset; asynchronous, active-low.
REQ-004: in_valid  input  1  operand pair offered.
REQ-005: in_ready  output  1  block can accept an operand pair.
REQ-006: in_a  input  WIDTH  operand A.
REQ-007: in_b  input  WIDTH  operand B.
REQ-008: in_cin  input  1  initial carry-in.
REQ-009: fa_a  output  1  bit of A presented to the external 1-bit full-adder cell.
REQ-010: fa_b  output  1  bit of B presented to the full-adder cell.
REQ-011: fa_ci  output  1  carry presented to the full-adder cell.
REQ-012: fa_sum  input  1  sum returned by the full-adder cell.
REQ-013: fa_co  input  1  carry-out returned by the full-adder cell.
REQ-014: out_valid  output  1  result available.
REQ-015: out_ready  input  1  consumer accepts the result.
REQ-016: out_sum  output  WIDTH  sum result.
REQ-017: out_cout  output  1  final carry-out.

Function
REQ-018: The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-019: in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-020: IDLE: on in_valid=1 at an edge, capture in_a, in_b into shift registers, carry register <= in_cin, bit counter <= 0, result register <= 0, go to RUN.
REQ-021: RUN: fa_a, fa_b, fa_ci SHALL be driven directly from the LSB of the A shift register, the LSB of the B shift register and the carry register (registered, no combinational path from inputs).
REQ-022: RUN, each edge: result register shifts right with fa_sum entering the MSB; carry <= fa_co; A and B shift right by one (zero fill); counter increments.
REQ-023: RUN SHALL last exactly WIDTH cycles; on the edge where counter reaches WIDTH-1, go to DONE.
REQ-024: Latency: operand accepted at edge k -> out_valid high after edge k+WIDTH.
REQ-025: DONE: out_sum = result register, out_cout = carry register; both SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026: DONE with out_ready=1 at an edge SHALL return to IDLE; minimum issue interval is WIDTH+2 cycles.
REQ-027: Outside RUN, fa_a, fa_b, fa_ci SHALL be 0.
REQ-028: out_sum/out_cout SHALL equal (in_a + in_b + in_cin) mod 2^(WIDTH+1), low WIDTH bits and top bit respectively.
REQ-029: in_valid while in RUN or DONE SHALL be ignored; operands are not sampled.
REQ-030: WIDTH=1: RUN lasts one cycle; counter width SHALL be at least 1 bit.
REQ-031: fa_sum/fa_co are sampled at the edge ending each RUN cycle; the cell's combinational delay SHALL be less than one clock period (system constraint, not checked by the block).

Reset
REQ-032: rst_n=0 SHALL immediately force: state IDLE, in_ready=1 (after reset release, as state is IDLE), out_valid=0, out_sum=0, out_cout=0, fa_a=fa_b=fa_ci=0, counter=0, all shift and carry registers 0.
REQ-033: rst_n asserted during RUN or DONE SHALL abort the operation; no result is delivered afterwards.

Verification
REQ-034: WIDTH=8, a=0x00, b=0x00, cin=0 -> out_valid 8 edges after accept, out_sum=0x00, out_cout=0.
REQ-035: WIDTH=8, a=0xFF, b=0x01, cin=0 -> out_sum=0x00, out_cout=1; fa_ci=1 in RUN cycles 1..7.
REQ-036: WIDTH=8, a=0xA5, b=0x5A, cin=1 -> out_sum=0x00, out_cout=1; in_ready=0 throughout RUN/DONE.
REQ-037: WIDTH=8, a=0x3C, b=0x0F, cin=0, out_ready held 0 for 5 cycles -> out_sum=0x4B, out_cout=0 stable all 5 cycles; IDLE one edge after out_ready=1.
REQ-038: Accept a=0xFF, b=0xFF, drop rst_n at RUN cycle 4 -> all outputs 0 immediately; after release, in_ready=1, no out_valid until a new accept.
REQ-039: Random sweep, WIDTH in {1,8,32}, back-to-back with out_ready=1 -> every result matches REQ-028; issue interval WIDTH+2 cycles.
